// File: rtl/id_stage_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_pipe_pkg
//  Description : Opcode/funct constants, ALU opcodes, enable levels and
//                operand-select enums shared by the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_stage_pipe_pkg;

    // Enable levels (reset is active-low)
    localparam logic c_READ_ENABLE  = 1'b1;
    localparam logic c_WRITE_ENABLE = 1'b1;
    localparam logic c_RST_ENABLE   = 1'b0;

    // Primary opcodes
    localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
    localparam logic [5:0] c_OP_ANDI    = 6'b001100;
    localparam logic [5:0] c_OP_ORI     = 6'b001101;
    localparam logic [5:0] c_OP_XORI    = 6'b001110;
    localparam logic [5:0] c_OP_LUI     = 6'b001111;
    localparam logic [5:0] c_OP_LW      = 6'b100011;
    localparam logic [5:0] c_OP_SW      = 6'b101011;

    // SPECIAL funct codes
    localparam logic [5:0] c_FN_SLL  = 6'b000000;
    localparam logic [5:0] c_FN_SRL  = 6'b000010;
    localparam logic [5:0] c_FN_SRA  = 6'b000011;
    localparam logic [5:0] c_FN_SLLV = 6'b000100;
    localparam logic [5:0] c_FN_SRLV = 6'b000110;
    localparam logic [5:0] c_FN_SRAV = 6'b000111;
    localparam logic [5:0] c_FN_MOVZ = 6'b001010;
    localparam logic [5:0] c_FN_MOVN = 6'b001011;
    localparam logic [5:0] c_FN_AND  = 6'b100100;
    localparam logic [5:0] c_FN_OR   = 6'b100101;
    localparam logic [5:0] c_FN_XOR  = 6'b100110;
    localparam logic [5:0] c_FN_NOR  = 6'b100111;

    // ALU opcodes seen by EX (variable and immediate shifts share one code)
    localparam logic [7:0] c_ALU_NOP  = 8'h00;
    localparam logic [7:0] c_ALU_SRL  = 8'h02;
    localparam logic [7:0] c_ALU_SRA  = 8'h03;
    localparam logic [7:0] c_ALU_SLL  = 8'h04;
    localparam logic [7:0] c_ALU_MOVZ = 8'h0A;
    localparam logic [7:0] c_ALU_MOVN = 8'h0B;
    localparam logic [7:0] c_ALU_ADD  = 8'h20;
    localparam logic [7:0] c_ALU_AND  = 8'h24;
    localparam logic [7:0] c_ALU_OR   = 8'h25;
    localparam logic [7:0] c_ALU_XOR  = 8'h26;
    localparam logic [7:0] c_ALU_NOR  = 8'h27;

    // Operand source selects
    typedef enum logic [1:0] {
        SRC1_RS    = 2'd0,
        SRC1_SHAMT = 2'd1,
        SRC1_ZERO  = 2'd2
    } src1_sel_e;

    typedef enum logic {
        SRC2_RT  = 1'b0,
        SRC2_IMM = 1'b1
    } src2_sel_e;

endpackage
`default_nettype wire

// File: rtl/id_stage_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_pipe_if
//  Description : IF/ID, register-file, EX and MEM/WB signals of the decode
//                stage. master = surrounding pipeline, slave = decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_stage_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 16
);
    logic                if_valid;
    logic [31:0]         if_pc;
    logic [31:0]         if_inst;
    logic                id_ready;
    logic                flush;
    logic [REG_AW-1:0]   rf_raddr1;
    logic [REG_AW-1:0]   rf_raddr2;
    logic [DATA_W-1:0]   rf_rdata1;
    logic [DATA_W-1:0]   rf_rdata2;
    logic [DATA_W-1:0]   ex_alu_result;
    logic                ex_ready;
    logic                wb_we;
    logic [REG_AW-1:0]   wb_waddr;
    logic [DATA_W-1:0]   wb_data;
    logic                ex_valid;
    logic                ex_regfile_we;
    logic                ex_mem_re;
    logic                ex_mem_we;
    logic [REG_AW-1:0]   ex_waddr;
    logic [ALUOP_W-1:0]  ex_alu_op;
    logic [DATA_W-1:0]   ex_src1;
    logic [DATA_W-1:0]   ex_src2;
    logic [DATA_W-1:0]   ex_store_data;
    logic [31:0]         ex_pc;
    logic [CNT_W-1:0]    stall_cnt;

    modport master (
        output if_valid, if_pc, if_inst, flush, rf_rdata1, rf_rdata2,
               ex_alu_result, ex_ready, wb_we, wb_waddr, wb_data,
        input  id_ready, rf_raddr1, rf_raddr2, ex_valid, ex_regfile_we,
               ex_mem_re, ex_mem_we, ex_waddr, ex_alu_op, ex_src1, ex_src2,
               ex_store_data, ex_pc, stall_cnt
    );

    modport slave (
        input  if_valid, if_pc, if_inst, flush, rf_rdata1, rf_rdata2,
               ex_alu_result, ex_ready, wb_we, wb_waddr, wb_data,
        output id_ready, rf_raddr1, rf_raddr2, ex_valid, ex_regfile_we,
               ex_mem_re, ex_mem_we, ex_waddr, ex_alu_op, ex_src1, ex_src2,
               ex_store_data, ex_pc, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/id_stage_pipe_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : id_decoder
//  Description : Combinational MIPS decoder: register reads, destination,
//                ALU opcode, operand selects, immediate and memory controls.
//                Unsupported encodings decode as a NOP with all enables low.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_decoder
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 8
) (
    input  logic [31:0]        i_inst,
    output logic [REG_AW-1:0]  o_rs,
    output logic [REG_AW-1:0]  o_rt,
    output logic               o_re1,
    output logic               o_re2,
    output logic               o_we,
    output logic [REG_AW-1:0]  o_waddr,
    output logic [ALUOP_W-1:0] o_alu_op,
    output src1_sel_e          o_src1_sel,
    output src2_sel_e          o_src2_sel,
    output logic [DATA_W-1:0]  o_imm,
    output logic [DATA_W-1:0]  o_shamt,
    output logic               o_mem_re,
    output logic               o_mem_we
);
    logic [5:0]        w_op;
    logic [5:0]        w_fn;
    logic [REG_AW-1:0] w_rd;
    logic [7:0]        w_alu;

    assign w_op     = i_inst[31:26];
    assign w_fn     = i_inst[5:0];
    assign o_rs     = REG_AW'(i_inst[25:21]);
    assign o_rt     = REG_AW'(i_inst[20:16]);
    assign w_rd     = REG_AW'(i_inst[15:11]);
    assign o_shamt  = DATA_W'(i_inst[10:6]);
    assign o_alu_op = ALUOP_W'(w_alu);

    // Instruction class decode; defaults describe the NOP
    always_comb begin
        o_re1      = 1'b0;
        o_re2      = 1'b0;
        o_we       = 1'b0;
        o_waddr    = '0;
        w_alu      = c_ALU_NOP;
        o_src1_sel = SRC1_ZERO;
        o_src2_sel = SRC2_IMM;
        o_imm      = '0;
        o_mem_re   = 1'b0;
        o_mem_we   = 1'b0;
        case (w_op)
            c_OP_SPECIAL: begin
                case (w_fn)
                    c_FN_OR, c_FN_AND, c_FN_XOR, c_FN_NOR, c_FN_MOVZ, c_FN_MOVN,
                    c_FN_SLLV, c_FN_SRLV, c_FN_SRAV: begin
                        o_re1      = c_READ_ENABLE;
                        o_re2      = c_READ_ENABLE;
                        o_we       = c_WRITE_ENABLE;
                        o_waddr    = w_rd;
                        o_src1_sel = SRC1_RS;
                        o_src2_sel = SRC2_RT;
                    end
                    c_FN_SLL, c_FN_SRL, c_FN_SRA: begin
                        o_re2      = c_READ_ENABLE;
                        o_we       = c_WRITE_ENABLE;
                        o_waddr    = w_rd;
                        o_src1_sel = SRC1_SHAMT;
                        o_src2_sel = SRC2_RT;
                    end
                    default: ;
                endcase
                case (w_fn)
                    c_FN_OR:              w_alu = c_ALU_OR;
                    c_FN_AND:             w_alu = c_ALU_AND;
                    c_FN_XOR:             w_alu = c_ALU_XOR;
                    c_FN_NOR:             w_alu = c_ALU_NOR;
                    c_FN_MOVZ:            w_alu = c_ALU_MOVZ;
                    c_FN_MOVN:            w_alu = c_ALU_MOVN;
                    c_FN_SLL, c_FN_SLLV:  w_alu = c_ALU_SLL;
                    c_FN_SRL, c_FN_SRLV:  w_alu = c_ALU_SRL;
                    c_FN_SRA, c_FN_SRAV:  w_alu = c_ALU_SRA;
                    default:              w_alu = c_ALU_NOP;
                endcase
            end
            c_OP_ORI, c_OP_ANDI, c_OP_XORI: begin
                o_re1      = c_READ_ENABLE;
                o_we       = c_WRITE_ENABLE;
                o_waddr    = o_rt;
                o_src1_sel = SRC1_RS;
                o_imm      = DATA_W'(i_inst[15:0]);
                w_alu      = (w_op == c_OP_ORI)  ? c_ALU_OR  :
                             (w_op == c_OP_ANDI) ? c_ALU_AND : c_ALU_XOR;
            end
            c_OP_LUI: begin
                o_we    = c_WRITE_ENABLE;
                o_waddr = o_rt;
                o_imm   = DATA_W'({i_inst[15:0], 16'h0000});
                w_alu   = c_ALU_OR;
            end
            c_OP_LW, c_OP_SW: begin
                o_re1      = c_READ_ENABLE;
                o_re2      = (w_op == c_OP_SW);
                o_we       = (w_op == c_OP_LW);
                o_waddr    = (w_op == c_OP_LW) ? o_rt : '0;
                o_src1_sel = SRC1_RS;
                o_imm      = DATA_W'($signed(i_inst[15:0]));
                w_alu      = c_ALU_ADD;
                o_mem_re   = (w_op == c_OP_LW);
                o_mem_we   = (w_op == c_OP_SW);
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_pipe
//  Description : Decode stage with forwarding, load-use bubble insertion,
//                EX back-pressure, flush and the ID/EX pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    id_stage_pipe_if.slave bus
);
    typedef struct packed {
        logic               valid;
        logic               regfile_we;
        logic               mem_re;
        logic               mem_we;
        logic [REG_AW-1:0]  waddr;
        logic [ALUOP_W-1:0] alu_op;
        logic [DATA_W-1:0]  src1;
        logic [DATA_W-1:0]  src2;
        logic [DATA_W-1:0]  store_data;
        logic [31:0]        pc;
    } idex_t;

    idex_t              r_idex;
    idex_t              w_idex_next;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [REG_AW-1:0]  w_rs, w_rt, w_waddr;
    logic               w_re1, w_re2, w_we, w_mem_re, w_mem_we;
    logic [ALUOP_W-1:0] w_alu_op;
    src1_sel_e          w_src1_sel;
    src2_sel_e          w_src2_sel;
    logic [DATA_W-1:0]  w_imm, w_shamt;
    logic [DATA_W-1:0]  w_fwd1, w_fwd2;
    logic               w_ex_fwd_ok;
    logic               w_hazard;
    logic               w_in_reset;

    id_decoder #(
        .DATA_W  (DATA_W),
        .REG_AW  (REG_AW),
        .ALUOP_W (ALUOP_W)
    ) u_dec (
        .i_inst     (bus.if_inst),
        .o_rs       (w_rs),
        .o_rt       (w_rt),
        .o_re1      (w_re1),
        .o_re2      (w_re2),
        .o_we       (w_we),
        .o_waddr    (w_waddr),
        .o_alu_op   (w_alu_op),
        .o_src1_sel (w_src1_sel),
        .o_src2_sel (w_src2_sel),
        .o_imm      (w_imm),
        .o_shamt    (w_shamt),
        .o_mem_re   (w_mem_re),
        .o_mem_we   (w_mem_we)
    );

    // r0 is hard zero; the held ALU result beats MEM/WB, which beats the RF
    function automatic logic [DATA_W-1:0] f_forward(
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] rf_data,
        input logic              ex_ok,
        input logic [REG_AW-1:0] ex_waddr,
        input logic [DATA_W-1:0] ex_data,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_waddr,
        input logic [DATA_W-1:0] wb_data
    );
        if (addr == '0)                         return '0;
        else if (ex_ok && (ex_waddr == addr))   return ex_data;
        else if (wb_we && (wb_waddr == addr))   return wb_data;
        else                                    return rf_data;
    endfunction

    assign w_in_reset  = (rst == c_RST_ENABLE);
    // A held load has no result yet, so it is never an EX forwarding source
    assign w_ex_fwd_ok = r_idex.valid & r_idex.regfile_we & ~r_idex.mem_re;
    assign w_fwd1 = f_forward(w_rs, bus.rf_rdata1, w_ex_fwd_ok, r_idex.waddr,
                              bus.ex_alu_result, bus.wb_we, bus.wb_waddr, bus.wb_data);
    assign w_fwd2 = f_forward(w_rt, bus.rf_rdata2, w_ex_fwd_ok, r_idex.waddr,
                              bus.ex_alu_result, bus.wb_we, bus.wb_waddr, bus.wb_data);

    // Load-use: the held load writes a register the incoming instruction reads
    assign w_hazard = bus.if_valid & r_idex.valid & r_idex.mem_re & (r_idex.waddr != '0) &
                      ((w_re1 & (w_rs == r_idex.waddr)) | (w_re2 & (w_rt == r_idex.waddr)));

    assign bus.id_ready  = ~w_in_reset & (bus.flush | (bus.ex_ready & ~w_hazard));
    assign bus.rf_raddr1 = w_in_reset ? '0 : w_rs;
    assign bus.rf_raddr2 = w_in_reset ? '0 : w_rt;

    // Assemble the ID/EX entry for the instruction currently in IF/ID
    always_comb begin
        w_idex_next            = '0;
        w_idex_next.valid      = 1'b1;
        w_idex_next.regfile_we = w_we;
        w_idex_next.mem_re     = w_mem_re;
        w_idex_next.mem_we     = w_mem_we;
        w_idex_next.waddr      = w_waddr;
        w_idex_next.alu_op     = w_alu_op;
        w_idex_next.pc         = bus.if_pc;
        case (w_src1_sel)
            SRC1_RS:    w_idex_next.src1 = w_fwd1;
            SRC1_SHAMT: w_idex_next.src1 = w_shamt;
            default:    w_idex_next.src1 = '0;
        endcase
        w_idex_next.src2       = (w_src2_sel == SRC2_RT) ? w_fwd2 : w_imm;
        w_idex_next.store_data = w_mem_we ? w_fwd2 : '0;
    end

    // ID/EX register and bubble counter: reset > flush > hold > bubble > load
    always_ff @(posedge clk) begin
        if (w_in_reset) begin
            r_idex      <= '0;
            r_stall_cnt <= '0;
        end else if (bus.flush) begin
            r_idex <= '0;
        end else if (!bus.ex_ready) begin
            r_idex <= r_idex;
        end else if (w_hazard) begin
            r_idex <= '0;
            if (r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end else if (bus.if_valid) begin
            r_idex <= w_idex_next;
        end else begin
            r_idex <= '0;
        end
    end

    assign bus.ex_valid      = r_idex.valid;
    assign bus.ex_regfile_we = r_idex.regfile_we;
    assign bus.ex_mem_re     = r_idex.mem_re;
    assign bus.ex_mem_we     = r_idex.mem_we;
    assign bus.ex_waddr      = r_idex.waddr;
    assign bus.ex_alu_op     = r_idex.alu_op;
    assign bus.ex_src1       = r_idex.src1;
    assign bus.ex_src2       = r_idex.src2;
    assign bus.ex_store_data = r_idex.store_data;
    assign bus.ex_pc         = r_idex.pc;
    assign bus.stall_cnt     = r_stall_cnt;
endmodule
`default_nettype wire
